key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NUM_KEYS, default 2: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clk cycles needed to accept a new key state (10 ms at 50 MHz); legal range is at least 2.
REQ-003 Parameter ACTIVE_LOW_IN, default 1: when 1, key_raw low means pressed.
REQ-004 clk  input  1  system clock; all state is on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 key_raw  input  NUM_KEYS  asynchronous board push-buttons, unsynchronized.
REQ-007 key_level  output  NUM_KEYS  debounced level, active-high pressed; feeds the key PIO in_port directly.
REQ-008 key_press  output  NUM_KEYS  one-cycle pulse per channel when key_level rises.
REQ-009 key_release  output  NUM_KEYS  one-cycle pulse per channel when key_level falls.

Function
REQ-010 Each channel shall pass key_raw through a 2-flop synchronizer; no other logic shall sit between the two flops.
REQ-011 Each channel shall normalise the synchronized value to active-high pressed: invert it when ACTIVE_LOW_IN=1, pass it through when ACTIVE_LOW_IN=0.
REQ-012 Each channel shall hold a counter of width $clog2(DEBOUNCE_CYCLES) that counts cycles in which the normalised value differs from key_level.
REQ-013 In any cycle where the normalised value equals key_level, the counter shall clear to 0, so any glitch shorter than DEBOUNCE_CYCLES is discarded.
REQ-014 In a mismatch cycle where the counter equals DEBOUNCE_CYCLES-1:
  - key_level shall toggle at that edge;
  - the counter shall clear to 0.
REQ-015 In a mismatch cycle below DEBOUNCE_CYCLES-1, the counter shall increment by 1.
REQ-016 The counter shall never exceed DEBOUNCE_CYCLES-1; there is no wrap-around.
REQ-017 Latency: after a clean key_raw transition, key_level shall change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
REQ-018 key_press shall be high for exactly the one cycle after key_level goes 0 to 1; key_release likewise for 1 to 0; both are registered.
REQ-019 key_press and key_release for the same channel shall never be high together.
REQ-020 Channels shall be fully independent; simultaneous transitions on several keys shall each be debounced and pulsed in the same cycles as if alone.
REQ-021 A raw value that bounces back to the accepted level before the count completes shall:
  - restart the count from 0;
  - produce no output change.

Reset
REQ-022 On reset_n low, asynchronously:
  - synchronizer flops shall go to the released raw level (1 if ACTIVE_LOW_IN=1, else 0);
  - counters shall go to 0;
  - key_level, key_press and key_release shall go to 0.
REQ-023 Reset asserted mid-count shall discard the partial count; no pulse shall be emitted on reset entry or exit.
REQ-024 A key held pressed through reset release shall be accepted as a normal press DEBOUNCE_CYCLES+2 edges later, with one key_press pulse.

Structure
REQ-025 Package key_pkg shall hold:
  - the default DEBOUNCE_CYCLES constant;
  - the simulation constant SIM_DEBOUNCE_CYCLES = 8;
  - the counter-width function.
REQ-026 Per-channel logic (synchronizer, counter, level, edge pulses) shall live in sub-module key_debounce_chan, instantiated NUM_KEYS times by a generate loop.
REQ-027 The top level shall contain only parameter propagation and bit-slice wiring.

Verification (DEBOUNCE_CYCLES=8, NUM_KEYS=2, ACTIVE_LOW_IN=1)
REQ-028 Clean press: reset, then key_raw[0] 1 to 0 held -> key_level[0]=1 at edge 10 after the first sampling edge; key_press[0] high for one cycle after; key_release stays 0.
REQ-029 Bounce: key_raw[0] low 5 cycles, high 1, low 20 -> key_level[0] rises exactly 10 edges after the final falling transition; exactly one key_press[0] pulse.
REQ-030 Glitch reject: key_raw[1] low for 7 cycles, then high -> key_level[1], key_press[1] and key_release[1] stay 0 throughout.
REQ-031 Simultaneous: both keys pressed on the same edge, then released 30 cycles later -> both key_level bits rise on the same cycle; key_press=2'b11 for one cycle; key_release=2'b11 for one cycle at release.
REQ-032 Reset mid-operation: assert reset_n after 4 mismatch cycles with key_raw[0] held low; release after 3 cycles -> outputs 0 during reset; key_level[0] rises 10 edges after reset release; one key_press[0] pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package key_pkg;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Short debounce window so simulations finish quickly
    localparam int SIM_DEBOUNCE_CYCLES = 8;

    // Width of a counter that has to reach cycles-1 without wrapping
    function automatic int key_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One push-button channel: synchronizer, stability counter, debounced
// level and registered press/release pulses.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW_IN   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int               CNT_W    = key_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Raw level of an untouched button
    localparam logic             RAW_IDLE = (ACTIVE_LOW_IN != 0);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             pressed;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= RAW_IDLE;
            sync2_reg <= RAW_IDLE;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalise to active-high pressed
    assign pressed = (ACTIVE_LOW_IN != 0) ? ~sync2_reg : sync2_reg;

    // Count consecutive disagreeing cycles; accept the new level once the
    // disagreement has lasted DEBOUNCE_CYCLES cycles, any agreement restarts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (pressed == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg     <= '0;
                level_reg   <= pressed;
                press_reg   <= pressed;
                release_reg <= ~pressed;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign key_level   = level_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer: one independent channel per key.
module key_debouncer
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW_IN   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
            ) u_chan (
                .clk         (clk),
                .reset_n     (reset_n),
                .key_raw     (key_raw[gi]),
                .key_level   (key_level[gi]),
                .key_press   (key_press[gi]),
                .key_release (key_release[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer with a short debounce window.
module tb_key_debouncer;
    import key_pkg::*;

    localparam int N = 2;
    localparam int D = SIM_DEBOUNCE_CYCLES;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] key_raw = '1;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;

    int n_tests = 0;
    int n_fail  = 0;

    key_debouncer #(
        .NUM_KEYS        (N),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW_IN   (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples travel through a two-stage delay line;
    // a key's accepted level flips once the delayed sample has disagreed with
    // it for D consecutive edges. Pulses come from comparing the accepted level
    // with its value one edge earlier.
    logic [N-1:0] m_d1, m_d2, m_level, m_level_prev;
    int           m_streak [N];
    logic [N-1:0] exp_press, exp_rel;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d1         <= '1;
            m_d2         <= '1;
            m_level      <= '0;
            m_level_prev <= '0;
            for (int i = 0; i < N; i++) m_streak[i] <= 0;
        end else begin
            m_d1         <= key_raw;
            m_d2         <= m_d1;
            m_level_prev <= m_level;
            for (int i = 0; i < N; i++) begin
                if ((!m_d2[i]) == m_level[i]) begin
                    m_streak[i] <= 0;
                end else if (m_streak[i] + 1 >= D) begin
                    m_streak[i] <= 0;
                    m_level[i]  <= ~m_level[i];
                end else begin
                    m_streak[i] <= m_streak[i] + 1;
                end
            end
        end
    end

    assign exp_press = m_level & ~m_level_prev;
    assign exp_rel   = ~m_level & m_level_prev;

    task automatic test_reset();
        reset_n = 1'b0;
        key_raw = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) key_raw = '0;
            n_tests++;
            if ({key_level, key_press, key_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d: lvl=%b prs=%b rel=%b, required all zero",
                         k, key_level, key_press, key_release);
            end
        end
        key_raw = '1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if ({key_level, key_press, key_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_exit k=%0d: lvl=%b prs=%b rel=%b, required all zero",
                         k, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_k = -1, fall_k = -1, presses = 0, releases = 0;
        key_raw[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 20) key_raw[0] = 1'b1;
            if (key_level[0] && rise_k < 0) rise_k = k;
            if (!key_level[0] && rise_k > 0 && fall_k < 0) fall_k = k;
            presses  += int'(key_press[0]);
            releases += int'(key_release[0]);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL clean_press k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (rise_k != D + 2 || presses != 1) begin
            n_fail++;
            $display("FAIL clean_press_latency: rise edge %0d presses %0d, required edge %0d presses 1",
                     rise_k, presses, D + 2);
        end
        n_tests++;
        if (fall_k != 20 + D + 2 || releases != 1) begin
            n_fail++;
            $display("FAIL clean_release_latency: fall edge %0d releases %0d, required edge %0d releases 1",
                     fall_k, releases, 20 + D + 2);
        end
    endtask

    task automatic test_bounce();
        int rise_k = -1, presses = 0;
        key_raw[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) key_raw[0] = 1'b1;
            if (k == 6) key_raw[0] = 1'b0;
            if (k == 26) key_raw[0] = 1'b1;
            if (key_level[0] && rise_k < 0) rise_k = k;
            presses += int'(key_press[0]);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL bounce k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (rise_k != 6 + D + 2 || presses != 1) begin
            n_fail++;
            $display("FAIL bounce_latency: rise edge %0d presses %0d, required edge %0d presses 1",
                     rise_k, presses, 6 + D + 2);
        end
    endtask

    // Low for D-1 samples is rejected, low for exactly D samples is accepted
    task automatic test_glitch();
        int activity = 0, presses = 0;
        key_raw[1] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == D - 1) key_raw[1] = 1'b1;
            activity += int'(key_level[1] | key_press[1] | key_release[1]);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL glitch k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (activity != 0) begin
            n_fail++;
            $display("FAIL glitch_reject: %0d active cycles on key 1, required 0", activity);
        end
        key_raw[1] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == D) key_raw[1] = 1'b1;
            presses += int'(key_press[1]);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL min_accept k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (presses != 1) begin
            n_fail++;
            $display("FAIL min_accept_press: %0d presses, required 1", presses);
        end
    endtask

    task automatic test_simultaneous();
        int rise_k = -1, fall_k = -1, both_press = 0, both_rel = 0;
        key_raw = 2'b00;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 30) key_raw = 2'b11;
            if (key_level == 2'b11 && rise_k < 0) rise_k = k;
            if (key_level == 2'b00 && rise_k > 0 && fall_k < 0) fall_k = k;
            both_press += int'(key_press == 2'b11);
            both_rel   += int'(key_release == 2'b11);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (rise_k != D + 2 || fall_k != 30 + D + 2 || both_press != 1 || both_rel != 1) begin
            n_fail++;
            $display("FAIL simultaneous_timing: rise %0d fall %0d press11 %0d rel11 %0d, required %0d %0d 1 1",
                     rise_k, fall_k, both_press, both_rel, D + 2, 30 + D + 2);
        end
    endtask

    task automatic test_reset_mid();
        int rise_k = -1, presses = 0;
        key_raw[0] = 1'b0;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        reset_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({key_level, key_press, key_release} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold k=%0d: lvl=%b prs=%b rel=%b, required all zero",
                         k, key_level, key_press, key_release);
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (key_level[0] && rise_k < 0) rise_k = k;
            presses += int'(key_press[0]);
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
        end
        n_tests++;
        if (rise_k != D + 2 || presses != 1) begin
            n_fail++;
            $display("FAIL reset_mid_latency: rise edge %0d presses %0d, required edge %0d presses 1",
                     rise_k, presses, D + 2);
        end
        key_raw[0] = 1'b1;
        for (int k = 1; k <= 2 * D + 4; k++) @(negedge clk);
    endtask

    task automatic test_random();
        int hold [N];
        int overlap = 0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            overlap += int'(|(key_press & key_release));
            n_tests++;
            if ({key_level, key_press, key_release} !== {m_level, exp_press, exp_rel}) begin
                n_fail++;
                $display("FAIL random k=%0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                         k, key_level, key_press, key_release, m_level, exp_press, exp_rel);
            end
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    key_raw[i] = 1'($urandom_range(0, 1));
                    hold[i]    = int'($urandom_range(1, 14));
                end else begin
                    hold[i]--;
                end
            end
        end
        n_tests++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL press_release_overlap: %0d cycles, required 0", overlap);
        end
        key_raw = '1;
        for (int k = 1; k <= 2 * D + 4; k++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
